// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared definitions for the CPU memory responder: FSM state
//               encoding, access-type encoding, default geometry and a
//               ceiling-log2 helper usable in parameter expressions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 512;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Smallest r such that 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Single-port RAM, synchronous write, combinational read of the
//               addressed word. The caller registers the read result.
// Ports       : clock - rising-edge clock
//               we    - write enable (din written to word idx on the edge)
//               idx   - word index
//               din   - write data
//               dout  - contents of word idx
// Parameters  : INIT_FILE - image name; contents start uninitialised
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int IDX_W     = clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[idx] <= din;
  end

  assign dout = mem_q[idx];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder for the control unit's MEMread/MEMwrite
//               strobes. Latches address/data/op on acceptance, waits
//               WAIT_STATES cycles, performs one RAM access, pulses ready for
//               one cycle, then holds until both strobes drop.
// Ports       : clock    - rising-edge clock
//               reset    - asynchronous active-low reset
//               MEMread  - read request level, held until ready
//               MEMwrite - write request level, held until ready (wins ties)
//               addr     - word address (MAR)
//               wdata    - store data (MDR)
//               rdata    - registered read data, changed only by reads
//               ready    - one-cycle completion pulse
//               busy     - high from acceptance until back in IDLE
//               fault    - out-of-range address, valid with ready
// Config      : MEM_ADDR_CHECK_EN - when defined, addr >= DEPTH faults (no
//               RAM access, read returns 0). When undefined the low index
//               bits are used (wrap-around) and fault is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MEMread,
  input  logic              MEMwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              fault
);

  localparam int IDX_W = clog2(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  op_e               op_q;
  logic              afault_q;
  logic [DATA_W-1:0] rdata_q;

  logic              req;
  logic              accept;
  logic              afault;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  assign req    = MEMread | MEMwrite;
  assign accept = (state_q == ST_IDLE) && req;

`ifdef MEM_ADDR_CHECK_EN
  assign afault = (addr >= ADDR_W'(DEPTH));
`else
  assign afault = 1'b0;
  // Upper address bits are deliberately ignored in wrap-around mode.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
`endif

  // --------------------------------------------------------------------------
  // FSM state and wait counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        // A faulting write must leave the RAM untouched.
        ram_we  = (op_q == OP_WRITE) && !afault_q;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: begin
        // Wait for the strobes to drop so a held request cannot re-trigger.
        if (!req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latches: captured once on acceptance, ignored afterwards
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q    <= '0;
      wdata_q  <= '0;
      op_q     <= OP_READ;
      afault_q <= 1'b0;
    end else if (accept) begin
      idx_q    <= addr[IDX_W-1:0];
      wdata_q  <= wdata;
      op_q     <= MEMwrite ? OP_WRITE : OP_READ;
      afault_q <= afault;
    end
  end

  // --------------------------------------------------------------------------
  // Read data register: only reads update it
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if ((state_q == ST_ACCESS) && (op_q == OP_READ)) begin
      rdata_q <= afault_q ? '0 : ram_dout;
    end
  end

  mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_mem_array (
    .clock (clock),
    .we    (ram_we),
    .idx   (idx_q),
    .din   (wdata_q),
    .dout  (ram_dout)
  );

  assign rdata = rdata_q;
  assign ready = (state_q == ST_DONE);
  assign busy  = (state_q != ST_IDLE);
  assign fault = ready & afault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder: directed table of
//               transactions, reset corner cases, then random transactions
//               checked against a word-array reference model.
// Config      : honours MEM_ADDR_CHECK_EN for expected fault behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int WS    = 1;
  localparam int DEPTH = 512;
`ifdef MEM_ADDR_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        MEMread = 1'b0;
  logic        MEMwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        fault;

  int errs   = 0;
  int checks = 0;

  // Reference model: one entry per RAM word, plus which words are known.
  logic [31:0] mem_m   [DEPTH];
  bit          known_m [DEPTH];
  logic [31:0] last_rd;

  always #5 clock = ~clock;

  mem_responder #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS),
    .INIT_FILE   ("")
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .MEMread  (MEMread),
    .MEMwrite (MEMwrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .busy     (busy),
    .fault    (fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one request; called at posedge+1. Checks latency, single ready pulse,
  // busy release; returns rdata and fault seen with ready.
  task automatic xact(input bit wr, input bit rd, input logic [31:0] a,
                      input logic [31:0] d, input int hold,
                      output logic [31:0] rdv, output bit flt);
    int lat;
    MEMwrite = wr; MEMread = rd; addr = a; wdata = d;
    @(posedge clock); #1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    // Changes after acceptance must be ignored.
    addr = $urandom; wdata = $urandom;
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", lat, WS + 1);
    rdv = rdata;
    flt = fault;
    @(posedge clock); #1;
    chk("ready_single_pulse", {31'd0, ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("ready_while_held", {31'd0, ready}, 32'd0);
    end
    chk("busy_while_held", {31'd0, busy}, 32'd1);
    MEMwrite = 1'b0; MEMread = 1'b0;
    @(posedge clock); #1;
    chk("busy_after_drop", {31'd0, busy}, 32'd0);
  endtask

  // Model update; returns expected rdata/fault for the transaction.
  task automatic model(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] exp_rd, output bit exp_flt);
    int i;
    i = int'(a % DEPTH);
    exp_flt = CK && (a >= DEPTH);
    if (wr) begin
      if (!exp_flt) begin mem_m[i] = d; known_m[i] = 1'b1; end
    end else begin
      last_rd = exp_flt ? 32'd0 : mem_m[i];
    end
    exp_rd = last_rd;
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] a;
    logic [31:0] d;
    int          hold;
    logic [31:0] exp_rd;
    bit          exp_flt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] rdv, erd;
    bit          flt, eflt, wr, rd;
    logic [31:0] a, d;

    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    last_rd = 32'd0;

    tbl[0]  = '{1, 0, 32'h05A, 32'hDEADBEEF, 0,  32'h0,        0};
    tbl[1]  = '{0, 1, 32'h05A, 32'h0,        10, 32'hDEADBEEF, 0};
    tbl[2]  = '{1, 1, 32'h010, 32'h00001234, 0,  32'hDEADBEEF, 0};
    tbl[3]  = '{0, 1, 32'h010, 32'h0,        1,  32'h00001234, 0};
    tbl[4]  = '{1, 0, 32'h020, 32'h0,        0,  32'h00001234, 0};
    tbl[5]  = '{0, 1, 32'h020, 32'h0,        0,  32'h0,        0};
    tbl[6]  = '{1, 0, 32'h000, 32'h0BADF00D, 2,  32'h0,        0};
    tbl[7]  = '{1, 0, 32'h200, 32'hCAFEF00D, 0,  32'h0,        CK};
    tbl[8]  = '{0, 1, 32'h000, 32'h0,        0,  CK ? 32'h0BADF00D : 32'hCAFEF00D, 0};
    tbl[9]  = '{0, 1, 32'h200, 32'h0,        0,  CK ? 32'h0 : 32'hCAFEF00D, CK};
    tbl[10] = '{0, 1, 32'h05A, 32'h0,        0,  32'hDEADBEEF, 0};

    // Reset held for three cycles.
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_busy",  {31'd0, busy},  32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    // Directed table.
    for (int t = 0; t < 11; t++) begin
      xact(tbl[t].wr, tbl[t].rd, tbl[t].a, tbl[t].d, tbl[t].hold, rdv, flt);
      model(tbl[t].wr, tbl[t].a, tbl[t].d, erd, eflt);
      chk($sformatf("tbl%0d_rdata", t), rdv, tbl[t].exp_rd);
      chk($sformatf("tbl%0d_fault", t), {31'd0, flt}, {31'd0, tbl[t].exp_flt});
    end

    // Reset during the wait phase of a write: nothing committed.
    MEMwrite = 1'b1; addr = 32'h020; wdata = 32'h00000055;
    @(posedge clock); #1;
    chk("midop_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midop_reset_busy",  {31'd0, busy}, 32'd0);
    chk("midop_reset_rdata", rdata, 32'h0);
    @(posedge clock); #1;
    MEMwrite = 1'b0;
    reset = 1'b1;
    last_rd = 32'd0;
    @(posedge clock); #1;
    xact(1'b0, 1'b1, 32'h020, 32'h0, 0, rdv, flt);
    model(1'b0, 32'h020, 32'h0, erd, eflt);
    chk("midop_read_back", rdv, 32'h0);

    // Random transactions against the model.
    for (int n = 0; n < 150; n++) begin
      a = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 1000)) << 9);
      d  = $urandom;
      wr = ($urandom_range(0, 1) == 1);
      if (!wr && !(CK && a >= DEPTH) && !known_m[a % DEPTH]) wr = 1'b1;
      rd = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
      xact(wr, rd, a, d, int'($urandom_range(0, 3)), rdv, flt);
      model(wr, a, d, erd, eflt);
      chk("rand_rdata", rdv, erd);
      chk("rand_fault", {31'd0, flt}, {31'd0, eflt});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
